fir_sequencer: RTL and testbench

- Control FSM for the 4-tap FIR datapath.
- Sequences the shared register file and ALU through coefficient loading, sample storage, sample-history shift and the signed multiply-accumulate.
- Drives the modwait handshake and the err flag seen at the fir_filter top level.
- Sits between the input synchronizers (dr, lc) and the datapath and sample counter.

---
 rtl/fir_sequencer.sv | 82 ++++++++
 tb/tb_fir_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sequencer.sv
// fir_sequencer: control FSM sequencing the 4-tap FIR register file and ALU
module fir_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              dr,
  input  logic              lc,
  input  logic              overflow,
  output logic              cnt_up,
  output logic              clear,
  output logic              modwait,
  output logic [2:0]        op,
  output logic [ADDR_W-1:0] src1,
  output logic [ADDR_W-1:0] src2,
  output logic [ADDR_W-1:0] dest,
  output logic              err
);
  localparam logic [2:0] NOP = 3'd0, COPY = 3'd1, LD_S = 3'd2, LD_C = 3'd3,
                         ADD = 3'd4, SUB = 3'd5, MUL = 3'd6;
  typedef enum logic [4:0] {
    IDLE, LOADC, WAITC, STORE, ZERO, SORT1, SORT2, SORT3, SORT4,
    MUL1, ADD1, MUL2, SUB1, MUL3, ADD2, MUL4, SUB2, EIDLE
  } state_t;
  state_t state, next;
  logic [1:0] idx;
  // state, coefficient slot and the glitch-free flags decoded from next state
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      idx     <= 2'd0;
      modwait <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= next;
      idx     <= (state == LOADC) ? idx + 2'd1 : idx;
      modwait <= (next != IDLE) && (next != EIDLE);
      err     <= (next == EIDLE);
    end
  end
  // next-state and per-state datapath micro-op
  always_comb begin
    next   = state;
    cnt_up = 1'b0;
    clear  = 1'b0;
    op     = NOP;
    src1   = '0;
    src2   = '0;
    dest   = '0;
    case (state)
      IDLE:  next = lc ? LOADC : dr ? STORE : IDLE;
      LOADC: begin
        op    = LD_C;
        dest  = ADDR_W'(7) + ADDR_W'(idx);
        clear = (idx == 2'd0);
        next  = WAITC;
      end
      WAITC: next = lc ? WAITC : IDLE;
      STORE: begin
        op     = LD_S;
        dest   = ADDR_W'(5);
        cnt_up = dr;
        next   = dr ? ZERO : EIDLE;
      end
      ZERO:  begin op = SUB; next = overflow ? EIDLE : SORT1; end
      SORT1: begin op = COPY; src1 = ADDR_W'(3); dest = ADDR_W'(4); next = SORT2; end
      SORT2: begin op = COPY; src1 = ADDR_W'(2); dest = ADDR_W'(3); next = SORT3; end
      SORT3: begin op = COPY; src1 = ADDR_W'(1); dest = ADDR_W'(2); next = SORT4; end
      SORT4: begin op = COPY; src1 = ADDR_W'(5); dest = ADDR_W'(1); next = MUL1; end
      MUL1:  begin op = MUL; src1 = ADDR_W'(1); src2 = ADDR_W'(7);  dest = ADDR_W'(6); next = ADD1; end
      ADD1:  begin op = ADD; src2 = ADDR_W'(6); next = overflow ? EIDLE : MUL2; end
      MUL2:  begin op = MUL; src1 = ADDR_W'(2); src2 = ADDR_W'(8);  dest = ADDR_W'(6); next = SUB1; end
      SUB1:  begin op = SUB; src2 = ADDR_W'(6); next = overflow ? EIDLE : MUL3; end
      MUL3:  begin op = MUL; src1 = ADDR_W'(3); src2 = ADDR_W'(9);  dest = ADDR_W'(6); next = ADD2; end
      ADD2:  begin op = ADD; src2 = ADDR_W'(6); next = overflow ? EIDLE : MUL4; end
      MUL4:  begin op = MUL; src1 = ADDR_W'(4); src2 = ADDR_W'(10); dest = ADDR_W'(6); next = SUB2; end
      SUB2:  begin op = SUB; src2 = ADDR_W'(6); next = overflow ? EIDLE : IDLE; end
      EIDLE: next = lc ? LOADC : dr ? STORE : EIDLE;
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: directed plus randomized checks against a program-table model and an emulated datapath
module tb_fir_sequencer;
  logic tb_clk = 1'b0;
  logic n_reset = 1'b1;
  logic dr = 1'b0, lc = 1'b0, overflow = 1'b0;
  logic cnt_up, clear, modwait, err;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;
  int sample = 0, coeff = 0;
  int n_cmp = 0, n_bad = 0;
  int rf [16] = '{default: 0};
  localparam int M_IDLE = 0, M_LOADC = 1, M_WAITC = 2, M_SEQ = 3, M_ERR = 4;
  int m_mode = M_IDLE, m_step = 0, m_idx = 0, pend = 0, res_exp = 0;
  int h [4] = '{default: 0};
  int f [4] = '{default: 0};
  bit res_valid = 1'b0;
  logic [14:0] e_exp;

  fir_sequencer #(.ADDR_W(4)) dut (
    .clk(tb_clk), .n_reset(n_reset), .dr(dr), .lc(lc), .overflow(overflow),
    .cnt_up(cnt_up), .clear(clear), .modwait(modwait), .op(op),
    .src1(src1), .src2(src2), .dest(dest), .err(err)
  );

  always #5 tb_clk = ~tb_clk;

  // sample-sequence program: step 0 store, 1 zero, 2..5 history shift, then MUL/ADD-or-SUB per tap
  function automatic logic [14:0] prog(input int s);
    int k;
    k = (s - 6) / 2;
    if (s == 0) return {3'd2, 4'd0, 4'd0, 4'd5};
    if (s == 1) return {3'd5, 12'd0};
    if (s < 6) return {3'd1, 4'((s == 5) ? 5 : 5 - s), 4'd0, 4'(6 - s)};
    if (s % 2 == 0) return {3'd6, 4'(1 + k), 4'(7 + k), 4'd6};
    return {(k % 2 == 0) ? 3'd4 : 3'd5, 4'd0, 4'd6, 4'd0};
  endfunction

  function automatic bit ovf_step(input int s);
    return (s == 1) || (s >= 7 && s % 2 == 1);
  endfunction

  assign e_exp = (m_mode == M_SEQ) ? prog(m_step) :
                 (m_mode == M_LOADC) ? {3'd3, 8'd0, 4'(7 + m_idx)} : 15'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #2;
  endtask

  // behavioural sequencer model
  always @(posedge tb_clk or negedge n_reset) begin
    if (!n_reset) begin
      m_mode <= M_IDLE;
      m_step <= 0;
      m_idx <= 0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (m_mode)
        M_IDLE, M_ERR: begin
          if (lc) m_mode <= M_LOADC;
          else if (dr) begin m_mode <= M_SEQ; m_step <= 0; end
        end
        M_LOADC: begin
          f[m_idx] <= coeff;
          m_idx <= (m_idx + 1) % 4;
          m_mode <= M_WAITC;
        end
        M_WAITC: if (!lc) m_mode <= M_IDLE;
        default: begin
          if (m_step == 0) begin
            if (dr) begin pend <= sample; m_step <= 1; end
            else m_mode <= M_ERR;
          end else if (ovf_step(m_step) && overflow) m_mode <= M_ERR;
          else if (m_step == 13) begin
            m_mode <= M_IDLE;
            res_exp <= f[0] * h[0] - f[1] * h[1] + f[2] * h[2] - f[3] * h[3];
            res_valid <= 1'b1;
          end else begin
            if (m_step == 5) begin
              h[0] <= pend; h[1] <= h[0]; h[2] <= h[1]; h[3] <= h[2];
            end
            m_step <= m_step + 1;
          end
        end
      endcase
    end
  end

  // register-file/ALU emulation driven by the DUT micro-ops
  always @(posedge tb_clk) begin
    case (op)
      3'd1: rf[dest] <= rf[src1];
      3'd2: rf[dest] <= sample;
      3'd3: rf[dest] <= coeff;
      3'd4: rf[dest] <= rf[src1] + rf[src2];
      3'd5: rf[dest] <= rf[src1] - rf[src2];
      3'd6: rf[dest] <= rf[src1] * rf[src2];
      default: ;
    endcase
  end

  // per-cycle comparison against the model
  always @(negedge tb_clk) begin
    if (n_reset) begin
      check("op", op, e_exp[14:12]);
      check("src1", src1, e_exp[11:8]);
      check("src2", src2, e_exp[7:4]);
      check("dest", dest, e_exp[3:0]);
      check("modwait", modwait, (m_mode == M_LOADC || m_mode == M_WAITC || m_mode == M_SEQ));
      check("err", err, m_mode == M_ERR);
      check("cnt_up", cnt_up, m_mode == M_SEQ && m_step == 0 && dr);
      check("clear", clear, m_mode == M_LOADC && m_idx == 0);
      if (res_valid) check("fir_out", rf[0], res_exp);
    end
  end

  task automatic load_coeff(input int v, input int exp_dest);
    coeff = v;
    lc = 1'b1;
    tick();
    check("lc_op", op, 3);
    check("lc_dest", dest, exp_dest);
    check("lc_clear", clear, exp_dest == 7);
    check("lc_modwait", modwait, 1);
    tick();
    check("waitc_modwait", modwait, 1);
    lc = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_sample(input int v, input int exp_out);
    int cu, mw;
    cu = 0;
    mw = 0;
    sample = v;
    dr = 1'b1;
    tick();
    check("store_err", err, 0);
    for (int i = 0; i < 20; i++) begin
      if (cnt_up) cu++;
      if (modwait) mw++;
      tick();
      if (i == 0) dr = 1'b0;
    end
    check("cnt_up_pulses", cu, 1);
    check("modwait_cycles", mw, 14);
    check("fir_out_lit", rf[0], exp_out);
  endtask

  task automatic wait_step(input int k);
    for (int n = 0; n < 30 && !(m_mode == M_SEQ && m_step == k); n++) tick();
    check("reach_step", m_step, k);
  endtask

  task automatic wait_quiet();
    for (int n = 0; n < 60 && !(m_mode == M_IDLE || m_mode == M_ERR); n++) tick();
    check("quiet", (m_mode == M_IDLE || m_mode == M_ERR), 1);
  endtask

  initial begin
    #1 n_reset = 1'b0;
    tick();
    check("rst_modwait", modwait, 0);
    check("rst_err", err, 0);
    check("rst_op", op, 0);
    check("rst_cnt_up", cnt_up, 0);
    check("rst_clear", clear, 0);
    n_reset = 1'b1;
    tick();
    // coefficients 1,2,2,1 then four samples of 100
    load_coeff(1, 7);
    load_coeff(2, 8);
    load_coeff(2, 9);
    load_coeff(1, 10);
    send_sample(100, 100);
    send_sample(100, -100);
    send_sample(100, 100);
    send_sample(100, 0);
    // dr dropped before the STORE edge
    dr = 1'b1;
    tick();
    dr = 1'b0;
    #1 check("drop_cnt_up", cnt_up, 0);
    tick();
    check("drop_err", err, 1);
    check("drop_modwait", modwait, 0);
    check("drop_op", op, 0);
    send_sample(100, 0);
    check("recover_err", err, 0);
    // dr and lc together: coefficient load first, sample after
    coeff = 1;
    dr = 1'b1;
    lc = 1'b1;
    tick();
    check("both_op", op, 3);
    check("both_dest", dest, 7);
    lc = 1'b0;
    tick();
    tick();
    tick();
    check("both_store", op, 2);
    tick();
    dr = 1'b0;
    wait_quiet();
    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) dr = ~dr;
      if ($urandom_range(0, 15) == 0) lc = ~lc;
      overflow = ($urandom_range(0, 29) == 0);
      sample = int'($urandom_range(0, 200)) - 100;
      coeff = int'($urandom_range(0, 16)) - 8;
      tick();
    end
    dr = 1'b0;
    lc = 1'b0;
    overflow = 1'b0;
    tick();
    wait_quiet();
    // asynchronous reset during MUL2
    dr = 1'b1;
    tick();
    tick();
    dr = 1'b0;
    wait_step(8);
    #1 n_reset = 1'b0;
    #1;
    check("amid_modwait", modwait, 0);
    check("amid_err", err, 0);
    check("amid_op", op, 0);
    #2 n_reset = 1'b1;
    tick();
    dr = 1'b1;
    tick();
    check("restart_op", op, 2);
    check("restart_modwait", modwait, 1);
    tick();
    dr = 1'b0;
    wait_quiet();
    // overflow during ADD1, then lc clears err and loads slot 0
    dr = 1'b1;
    tick();
    tick();
    dr = 1'b0;
    wait_step(7);
    overflow = 1'b1;
    tick();
    overflow = 1'b0;
    check("ovf_err", err, 1);
    check("ovf_modwait", modwait, 0);
    check("ovf_op", op, 0);
    coeff = 5;
    lc = 1'b1;
    tick();
    check("ovf_lc_op", op, 3);
    check("ovf_lc_dest", dest, 7);
    check("ovf_lc_clear", clear, 1);
    check("ovf_lc_err", err, 0);
    tick();
    lc = 1'b0;
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
